riscv_core_mem_arbiter: RTL
===========================

RISCV_CORE_MEM_ARBITER -- requirements
Module: riscv_core_mem_arbiter

Interface
REQ-001 Parameter XLEN, default 64: data and address width.
REQ-002 i_clk  in  1: single clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1: reset, asynchronous and active-low.
REQ-004 i_arb_req0_valid  in  1: fetch-port read request (requester 0).
REQ-005 i_arb_req0_addr  in  XLEN: fetch-port address.
REQ-006 o_arb_req0_ready  out  1: fetch request accepted this cycle.
REQ-007 i_arb_req1_valid  in  1: data-port request (requester 1).
REQ-008 i_arb_req1_addr  in  XLEN: data-port address.
REQ-009 i_arb_req1_wdata  in  XLEN: data-port write data.
REQ-010 i_arb_req1_we  in  1: data-port write enable.
REQ-011 i_arb_req1_strb  in  XLEN/8: data-port byte strobes.
REQ-012 i_arb_req1_lock  in  1: AMO lock; holds the port for requester 1.
REQ-013 o_arb_req1_ready  out  1: data request accepted this cycle.
REQ-014 o_arb_rsp0_valid / o_arb_rsp1_valid  out  1 each: response to requester 0 / 1.
REQ-015 o_arb_rsp_rdata  out  XLEN: shared response data.
REQ-016 o_arb_mem_valid, o_arb_mem_addr (XLEN), o_arb_mem_wdata (XLEN), o_arb_mem_we (1), o_arb_mem_strb (XLEN/8)  out: memory request.
REQ-017 i_arb_mem_ready  in  1: memory accepts request.
REQ-018 i_arb_mem_rvalid  in  1; i_arb_mem_rdata  in  XLEN: memory response (reads and write acks).
REQ-019 o_arb_grant  out  1: current owner (0 = fetch, 1 = data); mux select.

Function
REQ-020 FSM states IDLE, REQ, RSP; one transaction outstanding at most.
REQ-021 IDLE: if any valid, ready asserted combinationally to exactly one winner; request fields captured; next state REQ.
REQ-022 Winner: single valid wins; both valid -> requester not granted last (round-robin pointer).
REQ-023 Lock active: only requester 1 eligible; req0 ready held 0 regardless of pointer.
REQ-024 Lock set when a requester-1 transaction with lock=1 completes; cleared when one with lock=0 completes.
REQ-025 REQ: o_arb_mem_valid=1 with captured fields stable until i_arb_mem_ready; then RSP.
REQ-026 REQ with i_arb_mem_ready and i_arb_mem_rvalid both 1: transaction completes, next state IDLE.
REQ-027 RSP: on i_arb_mem_rvalid, rsp_valid of granted requester =1 same cycle, rdata = i_arb_mem_rdata, next IDLE.
REQ-028 i_arb_mem_rvalid outside REQ/RSP ignored; no response generated.
REQ-029 Round-robin pointer updates on acceptance; earliest next acceptance is the cycle after completion.
REQ-030 Requester 0 transactions drive we=0, strb=0, wdata=0.
REQ-031 Minimum latency: accept cycle N, mem_valid N+1, response N+1 if memory answers immediately.

Reset
REQ-032 Reset asserted at any time: state IDLE, all outputs 0, grant 0, lock cleared, pointer = requester 1 granted last.
REQ-033 Reset mid-transaction abandons it; no response issued; memory is reset by the same i_rst_n.

Structure
REQ-034 State enum and XLEN default live in riscv_core_pkg.
REQ-035 One riscv_core_mux2x1 instance selects captured address between req0/req1, sel = arbiter winner.

Verification
REQ-036 Only req0 valid, addr 0x1000, mem ready+rvalid next cycle rdata 0xAA -> req0_ready N, mem_valid N+1, rsp0_valid N+1 rdata 0xAA.
REQ-037 Both valid continuously after reset -> grants alternate 0,1,0,1 over four transactions.
REQ-038 req1 lock=1 write completes, both then valid -> req1 granted again; after lock=0 completion req0 granted.
REQ-039 Memory stalls ready 3 cycles -> mem_valid and fields stable 4 cycles, no ready to either requester.
REQ-040 Reset asserted in RSP -> outputs 0 immediately; later rvalid produces no rsp_valid.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared types and helpers for the core memory arbiter
package riscv_core_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  // Winner index among eligible requesters; only meaningful when one is eligible.
  function automatic logic arb_pick(input logic elig0, input logic elig1, input logic last);
    if (elig0 && elig1) begin
      return ~last;
    end
    return elig1;
  endfunction

endpackage

// File: rtl/riscv_core_mux2x1.sv
// rtl/riscv_core_mux2x1.sv - generic two-input multiplexer
module riscv_core_mux2x1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// rtl/riscv_core_mem_arbiter.sv - round-robin fetch/data arbiter onto one memory port
module riscv_core_mem_arbiter
  import riscv_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_arb_req0_valid,
  input  logic [XLEN-1:0]   i_arb_req0_addr,
  output logic              o_arb_req0_ready,
  input  logic              i_arb_req1_valid,
  input  logic [XLEN-1:0]   i_arb_req1_addr,
  input  logic [XLEN-1:0]   i_arb_req1_wdata,
  input  logic              i_arb_req1_we,
  input  logic [XLEN/8-1:0] i_arb_req1_strb,
  input  logic              i_arb_req1_lock,
  output logic              o_arb_req1_ready,
  output logic              o_arb_rsp0_valid,
  output logic              o_arb_rsp1_valid,
  output logic [XLEN-1:0]   o_arb_rsp_rdata,
  output logic              o_arb_mem_valid,
  output logic [XLEN-1:0]   o_arb_mem_addr,
  output logic [XLEN-1:0]   o_arb_mem_wdata,
  output logic              o_arb_mem_we,
  output logic [XLEN/8-1:0] o_arb_mem_strb,
  input  logic              i_arb_mem_ready,
  input  logic              i_arb_mem_rvalid,
  input  logic [XLEN-1:0]   i_arb_mem_rdata,
  output logic              o_arb_grant
);

  arb_state_e        state;
  logic              last_grant;
  logic              lock_q;
  logic              grant_q;
  logic              lock_cap_q;
  logic              mem_valid_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic [XLEN/8-1:0] strb_q;

  logic              elig0;
  logic              elig1;
  logic              any_elig;
  logic              winner;
  logic              accept;
  logic              rsp_fire;
  logic [XLEN-1:0]   addr_sel;

  // A held AMO lock shuts the fetch port out until the data port releases it.
  always_comb begin
    elig0    = i_arb_req0_valid & ~lock_q;
    elig1    = i_arb_req1_valid;
    any_elig = elig0 | elig1;
    winner   = arb_pick(elig0, elig1, last_grant);
    accept   = (state == ARB_IDLE) & any_elig;
    rsp_fire = i_arb_mem_rvalid &
               (((state == ARB_REQ) & i_arb_mem_ready) | (state == ARB_RSP));
  end

  riscv_core_mux2x1 #(
    .WIDTH (XLEN)
  ) u_addr_mux (
    .d0  (i_arb_req0_addr),
    .d1  (i_arb_req1_addr),
    .sel (winner),
    .y   (addr_sel)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ARB_IDLE;
      last_grant  <= 1'b1;
      lock_q      <= 1'b0;
      grant_q     <= 1'b0;
      lock_cap_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      strb_q      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_elig) begin
            state       <= ARB_REQ;
            mem_valid_q <= 1'b1;
            grant_q     <= winner;
            last_grant  <= winner;
            addr_q      <= addr_sel;
            wdata_q     <= winner ? i_arb_req1_wdata : '0;
            we_q        <= winner & i_arb_req1_we;
            strb_q      <= winner ? i_arb_req1_strb : '0;
            lock_cap_q  <= winner & i_arb_req1_lock;
          end
        end
        ARB_REQ: begin
          if (i_arb_mem_ready) begin
            mem_valid_q <= 1'b0;
            if (i_arb_mem_rvalid) begin
              state <= ARB_IDLE;
              if (grant_q) begin
                lock_q <= lock_cap_q;
              end
            end else begin
              state <= ARB_RSP;
            end
          end
        end
        ARB_RSP: begin
          if (i_arb_mem_rvalid) begin
            state <= ARB_IDLE;
            if (grant_q) begin
              lock_q <= lock_cap_q;
            end
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Readies are combinational, so they are masked while reset is held.
  assign o_arb_req0_ready = i_rst_n & accept & ~winner;
  assign o_arb_req1_ready = i_rst_n & accept & winner;
  assign o_arb_rsp0_valid = rsp_fire & ~grant_q;
  assign o_arb_rsp1_valid = rsp_fire & grant_q;
  assign o_arb_rsp_rdata  = rsp_fire ? i_arb_mem_rdata : '0;
  assign o_arb_mem_valid  = mem_valid_q;
  assign o_arb_mem_addr   = addr_q;
  assign o_arb_mem_wdata  = wdata_q;
  assign o_arb_mem_we     = we_q;
  assign o_arb_mem_strb   = strb_q;
  assign o_arb_grant      = grant_q;

endmodule
